// File: rtl/regfile_sb.sv
// Parametrised multi-read, single-write integer register file with x0 hardwired to zero,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*XLEN-1:0]  rd,
   output logic [NRD-1:0]       rd_busy,
   input  logic                 we,
   input  logic [AW-1:0]        wa,
   input  logic [XLEN-1:0]      wd,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_addr,
   output logic [NREGS-1:0]     busy_vec
);

   logic [XLEN-1:0]  x_reg [NREGS];
   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            x_reg[r] <= '0;
         end
         busy_reg <= '0;
      end else begin
         if (we && (wa != '0)) begin
            x_reg[wa] <= wd;
         end
         busy_reg <= busy_next;
      end
   end

   // A new issue to the same register outranks the retiring write's clear.
   assign busy_next[0] = 1'b0;
   genvar gi;
   generate
      for (gi = 1; gi < NREGS; gi++) begin : g_busy
         assign busy_next[gi] = (iss_en && (iss_addr == AW'(gi))) ? 1'b1 :
                                (we && (wa == AW'(gi)))           ? 1'b0 :
                                busy_reg[gi];
      end
   endgenerate

   assign busy_vec = busy_reg;

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0] addr;
         logic          hit;
         logic          set;
         assign addr = ra[gi*AW +: AW];
         assign hit  = (BYPASS != 0) && we && (wa == addr) && (wa != '0);
         assign set  = iss_en && (iss_addr == addr);
         assign rd[gi*XLEN +: XLEN] = (addr == '0) ? '0 :
                                      hit          ? wd :
                                      x_reg[addr];
         // Busy is hidden only when the bypassed data is the final value.
         assign rd_busy[gi] = busy_reg[addr] && !(hit && !set);
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: two regfile_sb instances (bypass on/off) share stimulus and are
// compared every cycle against an array-based model, plus literal checks for key scenarios.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  ra;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [63:0] rd_b, rd_n;
   logic [1:0]  rdb_b, rdb_n;
   logic [31:0] bv_b, bv_n;

   int checks = 0;
   int errors = 0;
   bit model_valid = 0;
   logic [31:0] mregs [32];
   bit          mbusy [32];

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_busy(rdb_b),
      .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(bv_b));

   regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_n), .rd_busy(rdb_n),
      .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(bv_n));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state advances on each rising edge from the inputs held across it.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) begin
            mregs[r] = '0;
            mbusy[r] = 0;
         end
         model_valid = 1;
      end else begin
         if (we && wa != 0) begin
            mregs[wa] = wd;
            mbusy[wa] = 0;
         end
         if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1;
      end
   end

   function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (byp && we && wa == a) return wd;
      return mregs[a];
   endfunction

   function automatic logic exp_busy(input bit byp, input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (byp && we && wa == a && !(iss_en && iss_addr == a)) return 1'b0;
      return mbusy[a];
   endfunction

   function automatic logic [31:0] exp_vec();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = mbusy[r];
      return v;
   endfunction

   always @(negedge clk) begin
      if (model_valid) begin
         chk("busy_vec_byp", bv_b, exp_vec());
         chk("busy_vec_nob", bv_n, exp_vec());
         if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
               logic [4:0] a;
               a = ra[i*5 +: 5];
               chk($sformatf("rd%0d_byp", i), rd_b[i*32 +: 32], exp_rd(1, a));
               chk($sformatf("rd%0d_nob", i), rd_n[i*32 +: 32], exp_rd(0, a));
               chk($sformatf("rd_busy%0d_byp", i), {31'b0, rdb_b[i]}, {31'b0, exp_busy(1, a)});
               chk($sformatf("rd_busy%0d_nob", i), {31'b0, rdb_n[i]}, {31'b0, exp_busy(0, a)});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 0; wa = 0; wd = 0; iss_en = 0; iss_addr = 0;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst_n = 0; ra = 0; idle();
      tick(); tick();
      rst_n = 1; ra = {5'd5, 5'd5};
      settle();
      chk("reset_busy_vec", bv_b, 32'h0);
      chk("reset_rd0", rd_b[31:0], 32'h0);

      // Reset clears a written register.
      we = 1; wa = 5; wd = 32'hDEADBEEF;
      tick(); idle();
      settle();
      chk("x5_written", rd_b[31:0], 32'hDEADBEEF);
      rst_n = 0;
      tick(); rst_n = 1;
      settle();
      chk("x5_after_reset", rd_b[31:0], 32'h0);
      chk("busy_after_reset", bv_n, 32'h0);

      // x0 ignores writes and issues.
      ra = 0; we = 1; wa = 0; wd = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0;
      settle();
      chk("x0_rd_same_cycle", rd_b[31:0], 32'h0);
      tick();
      settle();
      chk("x0_rd_next", rd_n[31:0], 32'h0);
      chk("x0_busy", {31'b0, bv_b[0]}, 32'h0);
      idle();

      // Bypass versus no bypass.
      we = 1; wa = 7; wd = 32'h11111111;
      tick();
      wd = 32'h22222222; ra = {5'd7, 5'd7};
      settle();
      chk("byp_rd0", rd_b[31:0], 32'h22222222);
      chk("byp_rd1", rd_b[63:32], 32'h22222222);
      chk("byp_rd_busy", {30'b0, rdb_b}, 32'h0);
      chk("nob_rd0_old", rd_n[31:0], 32'h11111111);
      tick(); idle();
      settle();
      chk("nob_rd0_new", rd_n[31:0], 32'h22222222);

      // Scoreboard life cycle on x10.
      ra = {5'd0, 5'd10}; iss_en = 1; iss_addr = 10;
      tick(); idle();
      settle();
      chk("sb_busy_byp", {31'b0, rdb_b[0]}, 32'h1);
      chk("sb_busy_nob", {31'b0, rdb_n[0]}, 32'h1);
      tick();
      we = 1; wa = 10; wd = 32'h5;
      settle();
      chk("sb_retire_byp_busy", {31'b0, rdb_b[0]}, 32'h0);
      chk("sb_retire_byp_rd", rd_b[31:0], 32'h5);
      chk("sb_retire_nob_busy", {31'b0, rdb_n[0]}, 32'h1);
      tick(); idle();
      settle();
      chk("sb_cleared_vec", {31'b0, bv_n[10]}, 32'h0);
      chk("sb_cleared_rd", rd_n[31:0], 32'h5);

      // Same-cycle set and clear on x3: set wins, data commits.
      ra = {5'd0, 5'd3}; iss_en = 1; iss_addr = 3;
      tick();
      we = 1; wa = 3; wd = 32'h0000ABCD;
      settle();
      chk("coll_byp_busy", {31'b0, rdb_b[0]}, 32'h1);
      tick(); idle();
      settle();
      chk("coll_busy3", {31'b0, bv_b[3]}, 32'h1);
      chk("coll_rd", rd_n[31:0], 32'h0000ABCD);

      // Reset in the middle of pending work drops the write.
      iss_en = 1; iss_addr = 1; tick();
      iss_addr = 2; tick();
      iss_addr = 31; tick(); idle();
      settle();
      chk("mid_busy_before", bv_b, 32'h8000000E);
      rst_n = 0; we = 1; wa = 9; wd = 32'h99;
      tick(); rst_n = 1; idle(); ra = {5'd3, 5'd9};
      settle();
      chk("mid_rd9", rd_b[31:0], 32'h0);
      chk("mid_rd3", rd_n[63:32], 32'h0);
      chk("mid_busy_after", bv_n, 32'h0);

      // Randomised traffic, biased toward a few registers to force collisions.
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] r0, r1;
         rst_n    = ($urandom_range(0, 99) != 0);
         we       = $urandom_range(0, 1);
         wa       = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
         wd       = $urandom;
         iss_en   = ($urandom_range(0, 2) == 0);
         iss_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
         r0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom);
         ra = {r1, r0};
         tick();
      end
      rst_n = 1; idle();
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 2R1W integer register file, for the RV32I pipeline decode/writeback boundary.
- Adds configurable width, register count and read-port count, plus synchronous reset clearing of all registers.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard, so decode can detect RAW/load-use hazards without a separate hazard table.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, >=2); register 0 is hardwired zero.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = read returns the old value.
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ra  in  NRD*AW  read addresses, port i at ra[i*AW +: AW].
- rd  out  NRD*XLEN  read data, port i at rd[i*XLEN +: XLEN].
- rd_busy  out  NRD  port i's register has a pending write (scoreboard bit).
- we  in  1  write enable (writeback stage).
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- iss_en  in  1  issue marks a destination pending.
- iss_addr  in  AW  destination register being issued.
- busy_vec  out  NREGS  full scoreboard, bit r = register r pending.

Behaviour:
- Reset: synchronous, active-low, one clock edge. On rst_n=0 at the rising edge, all registers clear to 0 and all busy bits clear to 0. While rst_n=0, we and iss_en are ignored. Read ports stay combinational and return 0 after the reset edge.
- Read path: combinational, zero latency.
  - rd[i] = 0 if ra[i]==0.
  - Else if BYPASS==1 and we==1 and wa==ra[i] and wa!=0, rd[i] = wd.
  - Else rd[i] = x[ra[i]].
- Write: at the rising edge, x[wa] <= wd iff we==1 and wa!=0 (address test is separate from the enable; no reduction of we with wa). Writes to x0 are dropped.
- Scoreboard, per register r!=0, at the rising edge:
  - set: iss_en==1 and iss_addr==r.
  - clear: we==1 and wa==r.
  - set and clear on the same r in the same cycle: set wins (new producer issued as old one retires); busy[r] stays 1.
  - Clear without set: busy[r] <= 0. Set without clear: busy[r] <= 1.
  - A write to a non-busy register is legal; the bit stays 0.
- busy[0] is constant 0; issuing to x0 has no effect.
- rd_busy[i] = busy_vec[ra[i]], masked to 0 when BYPASS==1 and the same cycle's write clears that register with no same-register set. This means the bypassed data is valid.
- Multiple read ports may address the same register; all return identical data and busy status.
- Out-of-range addresses cannot occur (NREGS is a power of 2).
- All outputs are functions of state and current inputs only; no X after the first reset edge.
- Uninitialised behaviour before the first reset is undefined; the bench must reset first.

Test Plan:
- Reset clear: write x5=0xDEADBEEF, then hold rst_n=0 for 1 cycle -> ra0=5 reads 0x00000000; busy_vec==0.
- x0 immunity: we=1, wa=0, wd=0xFFFFFFFF, iss_en=1, iss_addr=0 -> ra0=0 reads 0, busy_vec[0]=0, on every cycle.
- Bypass: BYPASS=1, x7=0x11111111; same cycle we=1, wa=7, wd=0x22222222 with ra0=ra1=7 -> both ports read 0x22222222 combinationally, rd_busy=0. With BYPASS=0 the same stimulus reads 0x11111111 that cycle and 0x22222222 the next.
- Scoreboard life cycle: iss_en on x10 -> next cycle rd_busy[0]=1 for ra0=10. Write x10=0x5 two cycles later -> busy clears on that edge, and rd reads 0x5.
- Set/clear collision: x3 busy; same cycle we=1, wa=3, iss_en=1, iss_addr=3 -> after the edge x3 holds wd and busy[3]=1.
- Reset mid-operation: busy on x1, x2, x31 plus a pending write with rst_n=0 on the same edge -> all registers 0, busy_vec==0, and the write is not committed.
